// File: rtl/mul_product_accumulator_pkg.sv
// Shared constants and FSM encoding for the product accumulator.
// Holds the multiplier product width and the IDLE/ACC/HOLD state values.
package mul_product_accumulator_pkg;

    localparam int PRODUCT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Counter width able to hold the value burst_len itself.
    function automatic int cnt_width(input int burst_len);
        return $clog2(burst_len + 1);
    endfunction

endpackage

// File: rtl/mul_product_accumulator_acc_adder.sv
// Stateless ACC_W-bit unsigned adder with carry out for the accumulator.
// With `SATURATE_EN defined a carrying add clamps the sum to all-ones; otherwise it wraps.
module acc_adder
    import mul_product_accumulator_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             carry
);

    logic [ACC_W:0] wide_sum;

    always_comb begin
        wide_sum = {1'b0, a} + {1'b0, b};
        carry    = wide_sum[ACC_W];
`ifdef SATURATE_EN
        sum = carry ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];
`else
        sum = wide_sum[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/mul_product_accumulator.sv
// Sums each group of BURST_LEN products into one ACC_W-bit result with a sticky carry flag.
// Saturating adds are selected by defining `SATURATE_EN (see acc_adder).
module mul_product_accumulator
    import mul_product_accumulator_pkg::*;
#(
    parameter int DATA_W    = PRODUCT_W,
    parameter int ACC_W     = 24,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_ovf
);

    localparam int               CNT_W    = cnt_width(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic               beat;
    logic [ACC_W-1:0]   data_ext;
    logic [ACC_W-1:0]   add_sum;
    logic               add_carry;
    logic [CNT_W-1:0]   cnt_inc;

    assign data_ext = ACC_W'(in_data);
    assign cnt_inc  = cnt_q + CNT_W'(1);
    // clear also drops any product offered in the same cycle
    assign beat     = in_valid && in_ready && !clear;

    acc_adder #(
        .ACC_W (ACC_W)
    ) u_adder (
        .a     (acc_q),
        .b     (data_ext),
        .sum   (add_sum),
        .carry (add_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (beat) begin
                        acc_d   = data_ext;
                        cnt_d   = CNT_W'(1);
                        ovf_d   = 1'b0;
                        state_d = (BURST_LEN == 1) ? HOLD : ACC;
                    end
                end
                ACC: begin
                    if (beat) begin
                        acc_d = add_sum;
                        ovf_d = ovf_q | add_carry;
                        cnt_d = cnt_inc;
                        if (cnt_inc == LAST_CNT) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    // result stays frozen until the consumer takes it
                    if (out_ready) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Outputs come straight from registers, so out_ready never reaches in_ready.
    always_comb begin
        in_ready  = (state_q != HOLD);
        out_valid = (state_q == HOLD);
        out_data  = acc_q;
        out_ovf   = ovf_q;
    end

endmodule

// File: tb/tb_mul_product_accumulator.sv
// Bench for mul_product_accumulator: directed cases plus randomized multiplier traffic.
// A sum-per-burst model runs on every falling edge; a 17-bit instance covers the carry cases.
module tb_mul_product_accumulator;

    localparam int DATA_W    = 16;
    localparam int ACC_W     = 24;
    localparam int BURST_LEN = 4;
    localparam int B_ACC_W   = 17;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear, in_valid, in_ready, out_valid, out_ready, out_ovf;
    logic [DATA_W-1:0] in_data;
    logic [ACC_W-1:0]  out_data;

    logic               b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
    logic [DATA_W-1:0]  b_in_data;
    logic [B_ACC_W-1:0] b_out_data;

    int total = 0;
    int bad   = 0;

    longint unsigned m_sum;
    int              m_cnt;
    bit              m_pending;
    longint unsigned m_exp_data;
    bit              m_exp_ovf;
    int              m_results = 0;

    always #5 clk = ~clk;

    mul_product_accumulator #(
        .DATA_W    (DATA_W),
        .ACC_W     (ACC_W),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    mul_product_accumulator #(
        .DATA_W    (DATA_W),
        .ACC_W     (B_ACC_W),
        .BURST_LEN (BURST_LEN)
    ) dut_narrow (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (1'b0),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_ovf   (b_out_ovf)
    );

    task automatic checkOutput(input string name, input longint unsigned actual,
                               input longint unsigned expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Present one cycle of inputs to the main instance, return just after the edge.
    task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d,
                                 input logic ordy, input logic clr);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        clear     = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic narrowBeat(input logic v, input logic [DATA_W-1:0] d, input logic ordy);
        b_in_valid  = v;
        b_in_data   = d;
        b_out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    // Reference: each completed burst result is the plain sum of its products.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_sum     = 0;
            m_cnt     = 0;
            m_pending = 1'b0;
            checkOutput("reset out_valid", out_valid, 0);
            checkOutput("reset out_data", out_data, 0);
            checkOutput("reset out_ovf", out_ovf, 0);
        end else begin
            checkOutput("model in_ready", in_ready, !m_pending);
            checkOutput("model out_valid", out_valid, m_pending);
            if (m_pending) begin
                checkOutput("model out_data", out_data, m_exp_data);
                checkOutput("model out_ovf", out_ovf, m_exp_ovf);
            end
            if (clear) begin
                m_sum     = 0;
                m_cnt     = 0;
                m_pending = 1'b0;
            end else if (m_pending) begin
                if (out_ready) begin
                    m_pending = 1'b0;
                    m_results++;
                end
            end else if (in_valid) begin
                m_sum += in_data;
                m_cnt++;
                if (m_cnt == BURST_LEN) begin
                    m_exp_ovf = (m_sum >> ACC_W) != 0;
`ifdef SATURATE_EN
                    m_exp_data = m_exp_ovf ? ((64'd1 << ACC_W) - 1) : m_sum;
`else
                    m_exp_data = m_sum & ((64'd1 << ACC_W) - 1);
`endif
                    m_pending = 1'b1;
                    m_sum     = 0;
                    m_cnt     = 0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] a, b;
        logic [31:0] full;
        logic        v, ordy, clr, taken;
        int          sent, cycles, bad_before, res_before;

        rst_n = 1'b0;
        clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Test 1: back-to-back burst, result one cycle after the last beat
        for (int i = 0; i < 4; i++) begin
            if (i == 3) checkOutput("t1 valid before last beat", out_valid, 0);
            applyStimulus(1'b1, 16'((i + 1) * 16'h1000), 1'b1, 1'b0);
        end
        checkOutput("t1 out_valid", out_valid, 1);
        checkOutput("t1 out_data", out_data, 24'h00A000);
        checkOutput("t1 out_ovf", out_ovf, 0);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        checkOutput("t1 out_valid dropped", out_valid, 0);

        // Test 2: backpressure holds the result and blocks new products
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'((i + 1) * 16'h1000), 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            checkOutput("t2 out_valid held", out_valid, 1);
            checkOutput("t2 out_data held", out_data, 24'h00A000);
            checkOutput("t2 in_ready low", in_ready, 0);
            applyStimulus(1'b1, 16'h7777, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        checkOutput("t2 out_valid after take", out_valid, 0);
        checkOutput("t2 in_ready after take", in_ready, 1);

        // Test 3: 17-bit accumulator, four beats of 0xFFFF
        for (int i = 0; i < 4; i++) narrowBeat(1'b1, 16'hFFFF, 1'b0);
        b_in_valid = 1'b0;
        checkOutput("t3 out_valid", b_out_valid, 1);
`ifdef SATURATE_EN
        checkOutput("t3 out_data", b_out_data, 17'h1FFFF);
`else
        checkOutput("t3 out_data", b_out_data, 17'h1FFFC);
`endif
        checkOutput("t3 out_ovf", b_out_ovf, 1);
        narrowBeat(1'b0, 16'h0, 1'b1);
        checkOutput("t3 out_valid dropped", b_out_valid, 0);
        checkOutput("t3 in_ready", b_in_ready, 1);
        for (int i = 0; i < 4; i++) narrowBeat(1'b1, 16'h0001, 1'b0);
        b_in_valid = 1'b0;
        checkOutput("t3 next burst data", b_out_data, 17'h00004);
        checkOutput("t3 next burst ovf cleared", b_out_ovf, 0);
        narrowBeat(1'b0, 16'h0, 1'b1);
        b_out_ready = 1'b0;

        // Test 4: reset mid-burst loses the partial sum
        applyStimulus(1'b1, 16'h0005, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h0005, 1'b1, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("t4 reset out_valid", out_valid, 0);
        checkOutput("t4 reset out_data", out_data, 0);
        checkOutput("t4 reset out_ovf", out_ovf, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'h0001, 1'b1, 1'b0);
        checkOutput("t4 out_valid", out_valid, 1);
        checkOutput("t4 out_data", out_data, 24'h000004);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);

        // Test 5: clear beats an output handshake in the same cycle
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'h0003, 1'b0, 1'b0);
        checkOutput("t5 in HOLD", out_valid, 1);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);
        checkOutput("t5 out_valid cleared", out_valid, 0);
        checkOutput("t5 in_ready", in_ready, 1);
        checkOutput("t5 out_data cleared", out_data, 0);
        checkOutput("t5 out_ovf cleared", out_ovf, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'h0002, 1'b1, 1'b0);
        checkOutput("t5 out_data", out_data, 24'h000008);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);

        // A product offered together with clear mid-burst is dropped
        applyStimulus(1'b1, 16'h0009, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0009, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'h0002, 1'b0, 1'b0);
        checkOutput("t5 clear in ACC out_data", out_data, 24'h000008);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);

        // Test 6: random multiplier traffic with gaps, stalls and rare clears
        bad_before = bad;
        res_before = m_results;
        sent   = 0;
        cycles = 0;
        a = 16'($urandom);
        b = 16'($urandom);
        while (sent < 100 && cycles < 5000) begin
            full  = a * b;
            v     = ($urandom_range(0, 9) < 7);
            ordy  = ($urandom_range(0, 9) < 6);
            clr   = ($urandom_range(0, 99) < 2);
            taken = v && in_ready && !clr;
            applyStimulus(v, full[15:0], ordy, clr);
            if (taken) begin
                sent++;
                a = 16'($urandom);
                b = 16'($urandom);
            end
            cycles++;
        end
        repeat (3) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        checkOutput("t6 within cycle budget", (cycles < 5000), 1);
        checkOutput("t6 results produced", (m_results > res_before + 10), 1);
        if (bad != bad_before) $display("[TB] Wrong Answer");
        else $display("[TB] Ok");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
